imem_row_scheduler: RTL
=======================

Name: imem_row_scheduler

Overview:
Sequences row delivery from the IFMAP memory to the five PPEs (IDs 5-9). It runs the initial row preload once weights are loaded. It then arbitrates PPE row requests round-robin, tracks a per-PPE row pointer, and advances from timestep 1 to timestep 2. It drives the IFMAP memory read port and emits 33-bit router packets of the form [32:29] dest, [28:25] opcode, [24:0] data.

Parameters:
IFMAP_SIZE, 25, rows per map and bits per row
NUM_PPE, 5, number of PPEs served
PPE_BASE_ID, 5, router ID of the first PPE
OP_PPE_INPUT, 1, opcode for a row-data packet
OP_ROW_EXHAUSTED, 11, opcode for a reply to a request past the last row
NUM_TIMESTEPS, 2, timesteps per run

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
weights_done  in  1  one-cycle pulse: WMEM finished; start timestep 1
timestep_done  in  1  one-cycle pulse: current timestep complete
ppe_req  in  5  one-cycle request pulses; bit k = PPE (5+k)
mem_rd_en  out  1  memory read strobe
mem_rd_ts  out  1  timestep select (0 = ts1, 1 = ts2)
mem_rd_row  out  5  row index
mem_rd_data  in  25  row data, valid exactly 1 cycle after mem_rd_en
pkt_valid  out  1  packet valid
pkt_ready  in  1  router accepts packet
pkt  out  33  packet
cur_timestep  out  2  1 or 2; 0 before start
busy  out  1  high in any state except IDLE and DONE
sched_done  out  1  high in DONE

Behaviour:
- Reset values: all outputs 0 and state IDLE. This covers pkt, mem_rd_row, cur_timestep and the pending, pointer and latch registers. Reset mid-operation aborts any packet in flight; pkt_valid is 0 in the cycle after rst_n is sampled low.
- States and transitions:
  - IDLE: on weights_done go to PRELOAD with ts=1 and cur_timestep=1.
  - PRELOAD: for k=0..4, issue the read of row k and send it to PPE 5+k.
  - SERVE: arbitrate and service pending requests.
  - RD: assert mem_rd_en for 1 cycle.
  - CAP: register mem_rd_data into pkt[24:0].
  - SEND: hold pkt_valid until pkt_ready.
  - DONE: terminal until reset.
- Each read is RD(1 cycle) -> CAP(1 cycle) -> SEND. pkt_valid rises 2 cycles after mem_rd_en. The transfer completes on the first cycle pkt_valid && pkt_ready. pkt stays stable while valid and not ready.
- Pointers: ptr[k] is initialised to k+5 at the start of each timestep. Serving PPE k reads row ptr[k], then sets ptr[k] += 5.
- Exhausted pointer: if ptr[k] >= IFMAP_SIZE, skip RD/CAP and go straight to SEND. The packet is dest=5+k, opcode=OP_ROW_EXHAUSTED, data=0. The pointer does not advance.
- Pending requests:
  - A ppe_req bit sets pending[k].
  - The grant clears pending[k] when SEND completes.
  - If a new pulse for the same k arrives in that same cycle, set wins.
  - Requests arriving during IDLE are dropped. Requests arriving during PRELOAD or SEND are latched.
- Arbitration: round-robin, evaluated only in SERVE with no packet outstanding. After reset the priority order starts at PPE5. After granting k, the highest priority becomes (k+1) mod 5.
- Timestep handling:
  - timestep_done is latched in ts_done_pend from any state after IDLE.
  - It is acted on in SERVE only when pending==0 and no transaction is in flight.
  - If ts < NUM_TIMESTEPS: ts += 1, reinitialise the pointers, clear the latch, go to PRELOAD with mem_rd_ts=1. No weights_done is needed.
  - Otherwise go to DONE.
- Header: pkt[32:29] = 5+k; opcode = OP_PPE_INPUT for row data. Rows are 25 bits, so there is no width conversion; row index is 5 bits, unsigned.

Test Plan:
- Preload: weights_done with pkt_ready=1 and memory row r = 25'h1000000|r -> 5 packets, dest 5..9, opcode 1, data rows 0..4. mem_rd_en precedes each pkt_valid by 2 cycles.
- Simultaneous requests: ppe_req=5'b10101 in one cycle after preload -> grants in order PPE5, PPE7, PPE9, carrying rows 5, 7, 9. A following 5'b00001 is served before 5'b00100 only if PPE7 does not have priority; expected order follows the rotating pointer.
- Backpressure: pkt_ready=0 for 7 cycles during SEND -> pkt held bit-stable. A ppe_req arriving meanwhile is latched and served next.
- Exhaustion: PPE5 requests 5 times -> rows 5, 10, 15, 20, then opcode 11 with data 0. ptr stays at 25.
- Timestep: timestep_done while 2 requests are pending -> both are served first, then preload repeats with mem_rd_ts=1 and cur_timestep=2. A second timestep_done leads to sched_done=1 and busy=0.
- Reset: rst_n low while in SEND -> next cycle pkt_valid=0 and state IDLE. ppe_req is ignored until weights_done.

Source files
------------

// File: rtl/imem_row_scheduler_if.sv
// Memory read port, PPE request lines and router packet port of the IFMAP row scheduler.
// The master side is the scheduler. The slave side is the memory, the PPEs and the router.
interface imem_row_scheduler_if #(
    parameter int IFMAP_SIZE = 25,
    parameter int NUM_PPE    = 5,
    parameter int ROW_W      = 5
);
    logic [NUM_PPE-1:0]    ppe_req;
    logic                  mem_rd_en;
    logic                  mem_rd_ts;
    logic [ROW_W-1:0]      mem_rd_row;
    logic [IFMAP_SIZE-1:0] mem_rd_data;
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [IFMAP_SIZE+7:0] pkt;

    modport master (
        input  ppe_req, mem_rd_data, pkt_ready,
        output mem_rd_en, mem_rd_ts, mem_rd_row, pkt_valid, pkt
    );

    modport slave (
        output ppe_req, mem_rd_data, pkt_ready,
        input  mem_rd_en, mem_rd_ts, mem_rd_row, pkt_valid, pkt
    );
endinterface

// File: rtl/imem_row_scheduler.sv
// Sequences IFMAP rows to the PPEs. It runs a preload per timestep, then serves PPE row
// requests round-robin, and sends every row as a router packet {dest, opcode, data}.
module imem_row_scheduler #(
    parameter int IFMAP_SIZE       = 25,
    parameter int NUM_PPE          = 5,
    parameter int PPE_BASE_ID      = 5,
    parameter int OP_PPE_INPUT     = 1,
    parameter int OP_ROW_EXHAUSTED = 11,
    parameter int NUM_TIMESTEPS    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 weights_done,
    input  logic                 timestep_done,
    imem_row_scheduler_if.master bus,
    output logic [1:0]           cur_timestep,
    output logic                 busy,
    output logic                 sched_done
);
    localparam int ROW_W = $clog2(IFMAP_SIZE + 1);
    localparam int GW    = $clog2(NUM_PPE);
    localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(IFMAP_SIZE);
    localparam logic [ROW_W-1:0] PTR_STEP  = ROW_W'(NUM_PPE);
    localparam logic [GW-1:0]    LAST_PPE  = GW'(NUM_PPE - 1);
    localparam logic [1:0]       TS_LAST   = 2'(NUM_TIMESTEPS);

    typedef enum logic [2:0] {
        S_IDLE, S_PRELOAD, S_SERVE, S_RD, S_CAP, S_SEND, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            ts_q, ts_d;
    logic [ROW_W-1:0]      ptr_q [NUM_PPE];
    logic [ROW_W-1:0]      ptr_d [NUM_PPE];
    logic [NUM_PPE-1:0]    pend_q, pend_d;
    logic [GW-1:0]         prio_q, prio_d;
    logic [GW-1:0]         gnt_q, gnt_d;
    logic                  pre_q, pre_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [IFMAP_SIZE+7:0] pkt_q, pkt_d;
    logic                  tsd_q, tsd_d;

    logic                  send_done;
    logic                  found;
    logic [GW-1:0]         sel;
    logic [NUM_PPE-1:0]    pend_clr;
    int                    idx;

    function automatic logic [3:0] dest_of(input logic [GW-1:0] k);
        return 4'(PPE_BASE_ID + int'(k));
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ts_q    <= '0;
            pend_q  <= '0;
            prio_q  <= '0;
            gnt_q   <= '0;
            pre_q   <= 1'b0;
            row_q   <= '0;
            pkt_q   <= '0;
            tsd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            pend_q  <= pend_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            pre_q   <= pre_d;
            row_q   <= row_d;
            pkt_q   <= pkt_d;
            tsd_q   <= tsd_d;
        end
    end

    for (genvar gi = 0; gi < NUM_PPE; gi++) begin : g_ptr
        always_ff @(posedge clk) begin
            if (!rst_n) ptr_q[gi] <= '0;
            else        ptr_q[gi] <= ptr_d[gi];
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        pre_d   = pre_q;
        row_d   = row_q;
        pkt_d   = pkt_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        sel     = '0;
        idx     = 0;

        send_done = (state_q == S_SEND) && bus.pkt_ready;

        // A pulse in the completion cycle of its own grant survives: set after clear
        pend_clr = '0;
        if (send_done && !pre_q) pend_clr[gnt_q] = 1'b1;
        pend_d = pend_q & ~pend_clr;
        if (state_q != S_IDLE) pend_d = pend_d | bus.ppe_req;

        tsd_d = tsd_q | (timestep_done && (state_q != S_IDLE));

        // Rotating-priority search starting at prio_q
        for (int i = 0; i < NUM_PPE; i++) begin
            idx = int'(prio_q) + i;
            if (idx >= NUM_PPE) idx = idx - NUM_PPE;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (weights_done) begin
                    state_d = S_PRELOAD;
                    ts_d    = 2'd1;
                    pre_d   = 1'b1;
                    gnt_d   = '0;
                    for (int i = 0; i < NUM_PPE; i++) ptr_d[i] = ROW_W'(i + NUM_PPE);
                end
            end
            S_PRELOAD: begin
                row_d   = ROW_W'(gnt_q);
                state_d = S_RD;
            end
            S_SERVE: begin
                if (found) begin
                    gnt_d  = sel;
                    prio_d = (sel == LAST_PPE) ? '0 : sel + 1'b1;
                    pre_d  = 1'b0;
                    if (ptr_q[sel] >= ROW_LIMIT) begin
                        pkt_d   = {dest_of(sel), 4'(OP_ROW_EXHAUSTED), {IFMAP_SIZE{1'b0}}};
                        state_d = S_SEND;
                    end else begin
                        row_d      = ptr_q[sel];
                        ptr_d[sel] = ptr_q[sel] + PTR_STEP;
                        state_d    = S_RD;
                    end
                end else if (tsd_q) begin
                    tsd_d = 1'b0;
                    if (ts_q < TS_LAST) begin
                        ts_d    = ts_q + 2'd1;
                        pre_d   = 1'b1;
                        gnt_d   = '0;
                        state_d = S_PRELOAD;
                        for (int i = 0; i < NUM_PPE; i++) ptr_d[i] = ROW_W'(i + NUM_PPE);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                pkt_d   = {dest_of(gnt_q), 4'(OP_PPE_INPUT), bus.mem_rd_data};
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.pkt_ready) begin
                    if (pre_q && (gnt_q != LAST_PPE)) begin
                        gnt_d   = gnt_q + 1'b1;
                        state_d = S_PRELOAD;
                    end else begin
                        pre_d   = 1'b0;
                        state_d = S_SERVE;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.mem_rd_en  = (state_q == S_RD);
        bus.mem_rd_ts  = (ts_q == 2'd2);
        bus.mem_rd_row = row_q;
        bus.pkt_valid  = (state_q == S_SEND);
        bus.pkt        = pkt_q;
        cur_timestep   = ts_q;
        busy           = (state_q != S_IDLE) && (state_q != S_DONE);
        sched_done     = (state_q == S_DONE);
    end
endmodule
